// File: rtl/intcode_loader.sv
// Parses a comma-separated ASCII Intcode program one byte per cycle, writes each
// value to the core as a 64-bit word, optionally patches words 1/2, then runs to halt.
module intcode_loader #(
    parameter int  MAX_WORDS = 4096,
    parameter bit  PATCH_EN  = 1'b1,
    localparam int WCW       = $clog2(MAX_WORDS + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [63:0]    noun,
    input  logic [63:0]    verb,
    input  logic           in_valid,
    input  logic [7:0]     in_data,
    input  logic           in_last,
    output logic           in_ready,
    output logic           write_program,
    output logic [63:0]    data,
    output logic           run_program,
    input  logic           halt,
    output logic           done,
    output logic           error,
    output logic [WCW-1:0] word_count,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PARSE = 3'd1,
        S_EMIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    acc_q, acc_d;
    logic           neg_q, neg_d;
    logic           seen_q, seen_d;
    logic           last_q, last_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [63:0]    noun_q, noun_d;
    logic [63:0]    verb_q, verb_d;

    logic           is_digit, is_minus, is_comma, is_space;
    logic [63:0]    acc_next;
    logic [63:0]    value;

    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_minus = (in_data == 8'h2d);
    assign is_comma = (in_data == 8'h2c);
    assign is_space = (in_data == 8'h20) || (in_data == 8'h09) ||
                      (in_data == 8'h0d) || (in_data == 8'h0a);

    // acc*10 + digit, wrapping modulo 2^64; '0'..'9' carry the digit in the low nibble
    assign acc_next = (acc_q << 3) + (acc_q << 1) + {60'd0, in_data[3:0]};
    assign value    = neg_q ? (~acc_q + 64'd1) : acc_q;

    assign word_count = wcnt_q;
    assign state_dbg  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            seen_q  <= 1'b0;
            last_q  <= 1'b0;
            wcnt_q  <= '0;
            noun_q  <= '0;
            verb_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            seen_q  <= seen_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            noun_q  <= noun_d;
            verb_q  <= verb_d;
        end
    end

    // Input handshake: a byte moves only on a rising edge where in_valid and in_ready
    // are both high; in_ready depends on state alone, never on in_valid.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        neg_d         = neg_q;
        seen_d        = seen_q;
        last_d        = last_q;
        wcnt_d        = wcnt_q;
        noun_d        = noun_q;
        verb_d        = verb_q;
        in_ready      = 1'b0;
        write_program = 1'b0;
        data          = '0;
        run_program   = 1'b0;
        done          = 1'b0;
        error         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state_q == S_DONE);
                error = (state_q == S_ERROR);
                if (start) begin
                    state_d = S_PARSE;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    seen_d  = 1'b0;
                    last_d  = 1'b0;
                    wcnt_d  = '0;
                    noun_d  = noun;
                    verb_d  = verb;
                end
            end

            S_PARSE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_digit) begin
                        acc_d  = acc_next;
                        seen_d = 1'b1;
                        if (in_last) begin
                            state_d = S_EMIT;
                            last_d  = 1'b1;
                        end
                    end else if (is_minus) begin
                        // a sign with no digit after it on the final byte is a dangling field
                        if (seen_q || neg_q || in_last) state_d = S_ERROR;
                        else                            neg_d   = 1'b1;
                    end else if (is_space) begin
                        if (in_last) begin
                            if (seen_q) begin
                                state_d = S_EMIT;
                                last_d  = 1'b1;
                            end else if (neg_q || wcnt_q == '0) begin
                                state_d = S_ERROR;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    end else if (is_comma) begin
                        if (!seen_q) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_EMIT;
                            last_d  = in_last;
                        end
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_EMIT: begin
                acc_d  = '0;
                neg_d  = 1'b0;
                seen_d = 1'b0;
                last_d = 1'b0;
                if (wcnt_q == WCW'(MAX_WORDS)) begin
                    state_d = S_ERROR;
                end else begin
                    write_program = 1'b1;
                    if (PATCH_EN && wcnt_q == WCW'(1))      data = noun_q;
                    else if (PATCH_EN && wcnt_q == WCW'(2)) data = verb_q;
                    else                                    data = value;
                    wcnt_d  = wcnt_q + WCW'(1);
                    state_d = last_q ? S_RUN : S_PARSE;
                end
            end

            S_RUN: begin
                run_program = 1'b1;
                if (halt) state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_intcode_loader.sv
// Bench for intcode_loader: three configurations share one driver, a sequential
// parser model supplies the expected words, strobe timing and final outcome.
module tb_intcode_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        drv_start, drv_valid, drv_last, drv_halt;
    logic [7:0]  drv_data;
    logic [63:0] noun, verb;
    int          sel;

    logic        rdy0, wp0, run0, done0, err0;
    logic        rdy1, wp1, run1, done1, err1;
    logic        rdy2, wp2, run2, done2, err2;
    logic [63:0] data0, data1, data2;
    logic [12:0] wc0, wc1;
    logic [1:0]  wc2;
    logic [2:0]  st0, st1, st2;

    intcode_loader #(.MAX_WORDS(4096), .PATCH_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start(drv_start && sel == 0), .noun(noun), .verb(verb),
        .in_valid(drv_valid && sel == 0), .in_data(drv_data), .in_last(drv_last),
        .in_ready(rdy0), .write_program(wp0), .data(data0), .run_program(run0),
        .halt(drv_halt && sel == 0), .done(done0), .error(err0), .word_count(wc0),
        .state_dbg(st0));

    intcode_loader #(.MAX_WORDS(4096), .PATCH_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .start(drv_start && sel == 1), .noun(noun), .verb(verb),
        .in_valid(drv_valid && sel == 1), .in_data(drv_data), .in_last(drv_last),
        .in_ready(rdy1), .write_program(wp1), .data(data1), .run_program(run1),
        .halt(drv_halt && sel == 1), .done(done1), .error(err1), .word_count(wc1),
        .state_dbg(st1));

    intcode_loader #(.MAX_WORDS(2), .PATCH_EN(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .start(drv_start && sel == 2), .noun(noun), .verb(verb),
        .in_valid(drv_valid && sel == 2), .in_data(drv_data), .in_last(drv_last),
        .in_ready(rdy2), .write_program(wp2), .data(data2), .run_program(run2),
        .halt(drv_halt && sel == 2), .done(done2), .error(err2), .word_count(wc2),
        .state_dbg(st2));

    logic        r_ready, r_wp, r_run, r_done, r_err;
    logic [63:0] r_data;
    logic [15:0] r_wc;

    always_comb begin
        case (sel)
            1: begin
                r_ready = rdy1; r_wp = wp1; r_run = run1; r_done = done1; r_err = err1;
                r_data = data1; r_wc = 16'(wc1);
            end
            2: begin
                r_ready = rdy2; r_wp = wp2; r_run = run2; r_done = done2; r_err = err2;
                r_data = data2; r_wc = 16'(wc2);
            end
            default: begin
                r_ready = rdy0; r_wp = wp0; r_run = run0; r_done = done0; r_err = err0;
                r_data = data0; r_wc = 16'(wc0);
            end
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // Reference model state
    logic [7:0]  prog_q[$];
    logic [63:0] exp_q[$];
    bit          term_q[$];
    bit          exp_err;
    bit          final_term;
    int          n_feed;
    int          exp_words;

    // Interprets the whole byte stream: which bytes produce a word, the words, and the outcome.
    task automatic model_run(input bit patch, input int maxw, input logic [63:0] nv,
                             input logic [63:0] vv);
        logic [63:0] acc;
        logic [7:0]  b;
        bit          neg, seen, fend, last;
        int          words;
        exp_q.delete();
        term_q.delete();
        exp_err = 0; final_term = 0; words = 0; acc = 0; neg = 0; seen = 0;
        n_feed = prog_q.size();
        for (int i = 0; i < prog_q.size(); i++) begin
            b    = prog_q[i];
            last = (i == prog_q.size() - 1);
            fend = 0;
            if (b >= 8'h30 && b <= 8'h39) begin
                acc  = acc * 64'd10 + 64'(b - 8'h30);
                seen = 1;
                fend = last;
            end else if (b == 8'h2d) begin
                if (seen || neg || last) exp_err = 1;
                else neg = 1;
            end else if (b == 8'h20 || b == 8'h09 || b == 8'h0d || b == 8'h0a) begin
                if (last) begin
                    if (seen) fend = 1;
                    else if (neg || words == 0) exp_err = 1;
                end
            end else if (b == 8'h2c) begin
                if (!seen) exp_err = 1;
                else fend = 1;
            end else begin
                exp_err = 1;
            end
            if (fend && words == maxw) exp_err = 1;
            term_q.push_back(fend && !exp_err);
            if (exp_err) begin
                n_feed = i + 1;
                break;
            end
            if (fend) begin
                if (patch && words == 1)      exp_q.push_back(nv);
                else if (patch && words == 2) exp_q.push_back(vv);
                else                          exp_q.push_back(neg ? -acc : acc);
                words++;
                acc = 0; neg = 0; seen = 0;
                if (last) final_term = 1;
            end
        end
        exp_words = words;
    endtask

    // Strobe/data scoreboard: a word-ending transfer must strobe exactly on the next cycle.
    bit          active = 0;
    bit          pend_term = 0;
    bit          mon_err = 0;
    int          xfer_idx = 0;
    logic [63:0] mon_ew;

    always @(negedge clk) begin
        if (active) begin
            check("strobe", 64'(r_wp), 64'(pend_term));
            mon_ew = 64'd0;
            if (pend_term && exp_q.size() > 0) mon_ew = exp_q.pop_front();
            check("data", r_data, mon_ew);
            if (mon_err) check("no_run", 64'(r_run), 64'd0);
            pend_term = 0;
            if (drv_valid && r_ready) begin
                if (xfer_idx < term_q.size()) pend_term = term_q[xfer_idx];
                xfer_idx++;
            end
        end
    end

    task automatic load_str(input string s);
        prog_q.delete();
        for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    endtask

    task automatic gen_prog();
        int          nf, nd;
        logic [7:0]  ws[4];
        ws[0] = 8'h20; ws[1] = 8'h09; ws[2] = 8'h0d; ws[3] = 8'h0a;
        prog_q.delete();
        nf = $urandom_range(1, 6);
        for (int f = 0; f < nf; f++) begin
            if ($urandom_range(0, 3) == 0) prog_q.push_back(8'h20);
            if ($urandom_range(0, 2) == 0) prog_q.push_back(8'h2d);
            nd = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 21);
            for (int d = 0; d < nd; d++) prog_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
            if ($urandom_range(0, 3) == 0) prog_q.push_back(ws[$urandom_range(0, 3)]);
            if ($urandom_range(0, 24) == 0) prog_q.push_back(8'h78);
            if (f < nf - 1 || $urandom_range(0, 1) == 1) prog_q.push_back(8'h2c);
        end
        if ($urandom_range(0, 2) == 0) prog_q.push_back(8'h0a);
        if (prog_q.size() == 0) prog_q.push_back(8'h30);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
        int w;
        ok = 1'b0;
        w  = 0;
        drv_valid = 1'b1;
        drv_data  = b;
        drv_last  = last;
        while (!ok && w < 40) begin
            drv_halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (r_ready) ok = 1'b1;
            else w++;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_halt  = 1'b0;
        if (!ok) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        drv_start = 1'b1;
        @(posedge clk);
        #1;
        drv_start = 1'b0;
    endtask

    task automatic run_test(input int s, input logic [63:0] nv, input logic [63:0] vv,
                            input int halt_wait);
        bit ok;
        sel = s;
        model_run(s == 0, (s == 2) ? 2 : 4096, nv, vv);
        noun = nv;
        verb = vv;
        pulse_start();
        noun = {$urandom, $urandom};
        verb = {$urandom, $urandom};
        xfer_idx  = 0;
        pend_term = 0;
        mon_err   = exp_err;
        active    = 1;
        @(negedge clk);
        check("start_wc", 64'(r_wc), 64'd0);
        check("start_flags", {61'd0, r_done, r_err, r_run}, 64'd0);
        check("start_ready", 64'(r_ready), 64'd1);
        @(posedge clk);
        #1;
        ok = 1'b1;
        for (int i = 0; i < n_feed && ok; i++)
            send_byte(prog_q[i], i == prog_q.size() - 1, ok);
        if (ok) begin
            if (exp_err) begin
                repeat (3) @(negedge clk);
                check("err_set", 64'(r_err), 64'd1);
                check("err_ready", 64'(r_ready), 64'd0);
                check("err_done", 64'(r_done), 64'd0);
                check("err_wc", 64'(r_wc), 64'(exp_words));
                check("err_words_left", 64'(exp_q.size()), 64'd0);
            end else begin
                if (final_term) begin
                    @(negedge clk);
                    check("run_early", 64'(r_run), 64'd0);
                end
                @(negedge clk);
                check("run_on", 64'(r_run), 64'd1);
                check("run_wc", 64'(r_wc), 64'(exp_words));
                check("run_words_left", 64'(exp_q.size()), 64'd0);
                @(posedge clk);
                #1;
                pulse_start();
                repeat (halt_wait) @(posedge clk);
                #1;
                @(negedge clk);
                check("run_hold", 64'(r_run), 64'd1);
                @(posedge clk);
                #1;
                drv_halt = 1'b1;
                @(posedge clk);
                #1;
                drv_halt = 1'b0;
                @(negedge clk);
                check("done_set", 64'(r_done), 64'd1);
                check("run_off", 64'(r_run), 64'd0);
                check("done_err", 64'(r_err), 64'd0);
            end
        end
        active = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1; drv_start = 1'b0; drv_valid = 1'b0; drv_last = 1'b0; drv_halt = 1'b0;
        drv_data = 8'h00; noun = '0; verb = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check("rst_outs", {58'd0, r_ready, r_wp, r_run, r_done, r_err, 1'b0}, 64'd0);
            check("rst_data", r_data, 64'd0);
            check("rst_wc", 64'(r_wc), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        load_str("1,0,0,3,99");
        run_test(1, 64'd0, 64'd0, 10);
        load_str("1,9,10,3,2,3,11,0,99,30,40,50");
        run_test(0, 64'd12, 64'd2, 5);
        load_str(" -5 ,\n7\n");
        run_test(1, 64'd0, 64'd0, 3);
        load_str("1,,2");
        run_test(1, 64'd0, 64'd0, 3);
        load_str("18446744073709551617");
        run_test(1, 64'd0, 64'd0, 3);
        load_str("1-2");
        run_test(1, 64'd0, 64'd0, 3);

        // asynchronous reset in the middle of "456" after "123," was written
        sel = 0;
        load_str("123,456");
        pulse_start();
        ok = 1'b1;
        for (int i = 0; i < 6 && ok; i++) send_byte(prog_q[i], 1'b0, ok);
        @(negedge clk);
        check("pre_rst_wc", 64'(r_wc), 64'd1);
        check("pre_rst_ready", 64'(r_ready), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_outs", {59'd0, r_ready, r_wp, r_run, r_done, r_err}, 64'd0);
        check("mid_rst_data", r_data, 64'd0);
        check("mid_rst_wc", 64'(r_wc), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        load_str("7");
        run_test(0, 64'd5, 64'd6, 3);

        load_str("1,2,3");
        run_test(2, 64'd0, 64'd0, 3);
        load_str("4,5");
        run_test(2, 64'd0, 64'd0, 2);

        for (int t = 0; t < 30; t++) begin
            gen_prog();
            run_test($urandom_range(0, 2), {$urandom, $urandom}, {$urandom, $urandom},
                     $urandom_range(0, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
